// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: FSM-sequenced multi-cycle MIPS core with internal register file,
// external synchronous instruction ROM and memory-mapped PortIn/PortOut.
// Optional feature macro RETIRE_COUNT_EN adds a 32-bit retired-instruction counter output.
module mips_multicycle_core #(
    parameter int          MEMORY_DEPTH  = 64,
    parameter logic [31:0] RESET_PC      = 32'h0040_0000,
    parameter int          PORT_IN_WIDTH = 8,
    parameter logic [31:0] IO_IN_ADDR    = 32'h1001_0024,
    parameter logic [31:0] IO_OUT_ADDR   = 32'h1001_0028
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run,
    output logic [$clog2(MEMORY_DEPTH)-1:0] instr_addr,
    input  logic [31:0]                     instr_data,
    input  logic [PORT_IN_WIDTH-1:0]        PortIn,
    output logic [31:0]                     PortOut,
    output logic [31:0]                     ALUResultOut,
    output logic                            halted
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0]                     retire_count
`endif
);
    localparam int AW = $clog2(MEMORY_DEPTH);
    localparam logic [31:0] WRAP_MASK = 32'(MEMORY_DEPTH * 4 - 1);
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} stateType;

    stateType state, nextState;
    logic [31:0] pc, ir, regA, regB, aluResult, wrData;
    logic [31:0] regs [32];
    logic [31:0] pcPlus4, sImm, zImm, branchTarget, jTarget, rsVal, rtVal;
    logic [5:0] dOp, dFunct, op, funct;
    logic [4:0] wrAddr;
    logic dLegal, isBranch, taken, wrEn, unusedIrBits;

    function automatic logic [31:0] wrapPc(input logic [31:0] a);
        return RESET_PC + ((a - RESET_PC) & WRAP_MASK);
    endfunction

    assign instr_addr = AW'((pc - RESET_PC) >> 2);
    assign halted = state == HALT;

    assign dOp = instr_data[31:26];
    assign dFunct = instr_data[5:0];
    assign dLegal = (dOp == OP_R && dFunct inside {F_ADD, F_SUB, F_AND, F_OR, F_NOR})
                 || dOp inside {OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW};
    assign rsVal = instr_data[25:21] == 5'd0 ? 32'd0 : regs[instr_data[25:21]];
    assign rtVal = instr_data[20:16] == 5'd0 ? 32'd0 : regs[instr_data[20:16]];

    assign op = ir[31:26];
    assign funct = ir[5:0];
    assign unusedIrBits = ^{ir[25:21], ir[10:6]};
    assign sImm = {{16{ir[15]}}, ir[15:0]};
    assign zImm = {16'h0, ir[15:0]};
    assign isBranch = op == OP_BEQ || op == OP_BNE;
    assign taken = op == OP_BEQ ? regA == regB : regA != regB;
    assign pcPlus4 = pc + 32'd4;
    assign branchTarget = pcPlus4 + {sImm[29:0], 2'b00};
    assign jTarget = {pcPlus4[31:28], instr_data[25:0], 2'b00};

    assign aluResult = op == OP_R ? (funct == F_SUB ? regA - regB :
                                     funct == F_AND ? regA & regB :
                                     funct == F_OR  ? regA | regB :
                                     funct == F_NOR ? ~(regA | regB) : regA + regB) :
                       op == OP_ORI ? regA | zImm :
                       op == OP_LUI ? {ir[15:0], 16'h0} :
                       isBranch ? regA - regB : regA + sImm;

    assign wrEn = op inside {OP_R, OP_ADDI, OP_ORI, OP_LUI, OP_LW};
    assign wrAddr = op == OP_R ? ir[15:11] : ir[20:16];
    assign wrData = op == OP_LW ? (ALUResultOut == IO_IN_ADDR ? 32'(PortIn) : 32'd0) : ALUResultOut;

    // State register
    always_ff @(posedge clk) begin
        state <= reset ? FETCH : nextState;
    end

    // Next-state sequencing
    always_comb begin
        nextState = state;
        case (state)
            FETCH:     nextState = run ? DECODE : FETCH;
            DECODE:    nextState = !dLegal ? HALT : (dOp == OP_J ? FETCH : EXECUTE);
            EXECUTE:   nextState = isBranch ? FETCH : WRITEBACK;
            WRITEBACK: nextState = FETCH;
            default:   nextState = HALT;
        endcase
    end

    // Datapath: PC, IR, operand latches, register file and I/O registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            ir <= '0;
            regA <= '0;
            regB <= '0;
            PortOut <= '0;
            ALUResultOut <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            if (state == DECODE) begin
                ir <= instr_data;
                regA <= rsVal;
                regB <= rtVal;
                if (dOp == OP_J) pc <= wrapPc(jTarget);
            end
            if (state == EXECUTE) begin
                ALUResultOut <= aluResult;
                if (isBranch) pc <= wrapPc(taken ? branchTarget : pcPlus4);
            end
            if (state == WRITEBACK) begin
                pc <= wrapPc(pcPlus4);
                if (wrEn && wrAddr != 5'd0) regs[wrAddr] <= wrData;
                if (op == OP_SW && ALUResultOut == IO_OUT_ADDR) PortOut <= regB;
            end
        end
    end

`ifdef RETIRE_COUNT_EN
    // Count instructions that complete by returning to FETCH
    always_ff @(posedge clk) begin
        if (reset) retire_count <= '0;
        else if (state != FETCH && nextState == FETCH) retire_count <= retire_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: scoreboard-driven bench for the multi-cycle MIPS core.
module tb_mips_multicycle_core;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    logic clk = 0, reset = 1, run = 1;
    logic [5:0] instr_addr;
    logic [31:0] instr_data;
    logic [7:0] PortIn = 8'hA5;
    logic [31:0] PortOut, ALUResultOut;
    logic halted;
`ifdef RETIRE_COUNT_EN
    logic [31:0] retire_count;
`endif
    logic [31:0] rom [64];
    int compared = 0, mismatched = 0;

    typedef struct {
        int          cyc;
        logic [31:0] alu;
        logic [5:0]  addr;
        logic [31:0] port;
    } expT;
    expT sb[$];

    mips_multicycle_core dut (
        .clk(clk), .reset(reset), .run(run), .instr_addr(instr_addr), .instr_data(instr_data),
        .PortIn(PortIn), .PortOut(PortOut), .ALUResultOut(ALUResultOut), .halted(halted)
`ifdef RETIRE_COUNT_EN
        , .retire_count(retire_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) instr_data <= rom[instr_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] rt3(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, f};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = ILLEGAL;
    endtask

    task automatic do_reset();
        reset = 1;
        run = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_rom();
        do_reset();
        compared++; if (instr_addr !== 6'd0) begin mismatched++; $display("FAIL reset_addr: got %h expected %h", instr_addr, 6'd0); end
        compared++; if (PortOut !== 32'd0) begin mismatched++; $display("FAIL reset_port: got %h expected %h", PortOut, 32'd0); end
        compared++; if (ALUResultOut !== 32'd0) begin mismatched++; $display("FAIL reset_alu: got %h expected %h", ALUResultOut, 32'd0); end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted: got %b expected 0", halted); end
`ifdef RETIRE_COUNT_EN
        compared++; if (retire_count !== 32'd0) begin mismatched++; $display("FAIL reset_retire: got %h expected 0", retire_count); end
`endif
    endtask

    task automatic test_arith();
        clear_rom();
        rom[0] = it(6'h08, 0, 8, 16'd5);         sb.push_back('{4, 32'h0000_0005, 6'd1, 32'h0});
        rom[1] = it(6'h08, 0, 9, 16'hFFFD);      sb.push_back('{4, 32'hFFFF_FFFD, 6'd2, 32'h0});
        rom[2] = rt3(6'h20, 8, 9, 10);           sb.push_back('{4, 32'h0000_0002, 6'd3, 32'h0});
        rom[3] = rt3(6'h22, 9, 8, 11);           sb.push_back('{4, 32'hFFFF_FFF8, 6'd4, 32'h0});
        rom[4] = it(6'h0F, 0, 16, 16'h1001);     sb.push_back('{4, 32'h1001_0000, 6'd5, 32'h0});
        rom[5] = it(6'h2B, 16, 10, 16'h0028);    sb.push_back('{4, 32'h1001_0028, 6'd6, 32'h2});
        rom[6] = it(6'h2B, 16, 11, 16'h0028);    sb.push_back('{4, 32'h1001_0028, 6'd7, 32'hFFFF_FFF8});
        rom[7] = rt3(6'h24, 9, 8, 12);           sb.push_back('{4, 32'h0000_0005, 6'd8, 32'hFFFF_FFF8});
        rom[8] = rt3(6'h25, 9, 8, 13);           sb.push_back('{4, 32'hFFFF_FFFD, 6'd9, 32'hFFFF_FFF8});
        rom[9] = rt3(6'h27, 8, 8, 14);           sb.push_back('{4, 32'hFFFF_FFFA, 6'd10, 32'hFFFF_FFF8});
        rom[10] = it(6'h0D, 9, 15, 16'h8002);    sb.push_back('{4, 32'hFFFF_FFFF, 6'd11, 32'hFFFF_FFF8});
        rom[11] = it(6'h08, 8, 24, 16'h8000);    sb.push_back('{4, 32'hFFFF_8005, 6'd12, 32'hFFFF_FFF8});
        do_reset();
        while (sb.size() > 0) begin
            expT e = sb.pop_front();
            repeat (3) tick();
            compared++; if (ALUResultOut !== e.alu) begin mismatched++; $display("FAIL arith_alu@%0d: got %h expected %h", e.addr, ALUResultOut, e.alu); end
            repeat (e.cyc - 3) tick();
            compared++; if (instr_addr !== e.addr) begin mismatched++; $display("FAIL arith_pc: got %0d expected %0d", instr_addr, e.addr); end
            compared++; if (PortOut !== e.port) begin mismatched++; $display("FAIL arith_port@%0d: got %h expected %h", e.addr, PortOut, e.port); end
        end
    endtask

    task automatic test_io();
        logic [31:0] prev = 32'h0;
        clear_rom();
        PortIn = 8'hA5;
        rom[0] = it(6'h0F, 0, 16, 16'h1001);     sb.push_back('{4, 32'h1001_0000, 6'd1, 32'h0});
        rom[1] = it(6'h23, 16, 8, 16'h0024);     sb.push_back('{4, 32'h1001_0024, 6'd2, 32'h0});
        rom[2] = it(6'h2B, 16, 8, 16'h0028);     sb.push_back('{4, 32'h1001_0028, 6'd3, 32'hA5});
        rom[3] = it(6'h08, 0, 0, 16'd7);         sb.push_back('{4, 32'h0000_0007, 6'd4, 32'hA5});
        rom[4] = it(6'h2B, 16, 0, 16'h0028);     sb.push_back('{4, 32'h1001_0028, 6'd5, 32'h0});
        rom[5] = it(6'h2B, 16, 8, 16'h0028);     sb.push_back('{4, 32'h1001_0028, 6'd6, 32'hA5});
        rom[6] = it(6'h2B, 16, 8, 16'h002C);     sb.push_back('{4, 32'h1001_002C, 6'd7, 32'hA5});
        rom[7] = it(6'h23, 16, 9, 16'h0020);     sb.push_back('{4, 32'h1001_0020, 6'd8, 32'hA5});
        rom[8] = it(6'h2B, 16, 9, 16'h0028);     sb.push_back('{4, 32'h1001_0028, 6'd9, 32'h0});
        do_reset();
        while (sb.size() > 0) begin
            expT e = sb.pop_front();
            repeat (3) tick();
            compared++; if (ALUResultOut !== e.alu) begin mismatched++; $display("FAIL io_alu@%0d: got %h expected %h", e.addr, ALUResultOut, e.alu); end
            compared++; if (PortOut !== prev) begin mismatched++; $display("FAIL io_port_early@%0d: got %h expected %h", e.addr, PortOut, prev); end
            repeat (e.cyc - 3) tick();
            compared++; if (instr_addr !== e.addr) begin mismatched++; $display("FAIL io_pc: got %0d expected %0d", instr_addr, e.addr); end
            compared++; if (PortOut !== e.port) begin mismatched++; $display("FAIL io_port@%0d: got %h expected %h", e.addr, PortOut, e.port); end
            prev = e.port;
        end
    endtask

    task automatic test_branch();
        clear_rom();
        rom[0] = it(6'h08, 0, 8, 16'd1);         sb.push_back('{4, 32'h1, 6'd1, 32'h0});
        rom[1] = it(6'h05, 8, 0, 16'd2);         sb.push_back('{3, 32'h1, 6'd4, 32'h0});
        rom[4] = it(6'h04, 8, 0, 16'd5);         sb.push_back('{3, 32'h1, 6'd5, 32'h0});
        rom[5] = it(6'h05, 0, 0, 16'd4);         sb.push_back('{3, 32'h0, 6'd6, 32'h0});
        rom[6] = it(6'h04, 0, 0, 16'hFFFF);
        for (int i = 0; i < 3; i++) sb.push_back('{3, 32'h0, 6'd6, 32'h0});
        do_reset();
        while (sb.size() > 0) begin
            expT e = sb.pop_front();
            repeat (3) tick();
            compared++; if (ALUResultOut !== e.alu) begin mismatched++; $display("FAIL br_alu: got %h expected %h", ALUResultOut, e.alu); end
            repeat (e.cyc - 3) tick();
            compared++; if (instr_addr !== e.addr) begin mismatched++; $display("FAIL br_pc: got %0d expected %0d", instr_addr, e.addr); end
        end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL br_halted: got %b expected 0", halted); end
    endtask

    task automatic test_halt();
        clear_rom();
        rom[0] = it(6'h0F, 0, 16, 16'h1001);
        rom[1] = it(6'h08, 0, 8, 16'd9);
        rom[2] = it(6'h2B, 16, 8, 16'h0028);
        do_reset();
        repeat (12) tick();
        compared++; if (PortOut !== 32'd9) begin mismatched++; $display("FAIL halt_pre_port: got %h expected %h", PortOut, 32'd9); end
        tick();
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL halt_early: got %b expected 0", halted); end
        tick();
        compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_set: got %b expected 1", halted); end
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            tick();
            compared++; if ({halted, instr_addr, PortOut, ALUResultOut} !== {1'b1, 6'd3, 32'd9, 32'h1001_0028}) begin
                mismatched++; $display("FAIL halt_frozen: got %b/%0d/%h/%h expected 1/3/00000009/10010028", halted, instr_addr, PortOut, ALUResultOut);
            end
        end
        do_reset();
        compared++; if ({halted, instr_addr, PortOut, ALUResultOut} !== {1'b0, 6'd0, 32'd0, 32'd0}) begin
            mismatched++; $display("FAIL halt_reset: got %b/%0d/%h/%h expected 0/0/0/0", halted, instr_addr, PortOut, ALUResultOut);
        end
        rom[0] = rt3(6'h21, 8, 9, 10);
        do_reset();
        repeat (2) tick();
        compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_funct: got %b expected 1", halted); end
    endtask

    task automatic test_run_and_abort();
        clear_rom();
        rom[0] = it(6'h08, 0, 8, 16'd5);
        rom[1] = rt3(6'h20, 8, 8, 9);
        rom[2] = rt3(6'h20, 9, 8, 10);
        do_reset();
        repeat (4) tick();
        compared++; if (ALUResultOut !== 32'd5) begin mismatched++; $display("FAIL run_first: got %h expected %h", ALUResultOut, 32'd5); end
        run = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            compared++; if ({instr_addr, ALUResultOut} !== {6'd1, 32'd5}) begin mismatched++; $display("FAIL run_stall: got %0d/%h expected 1/00000005", instr_addr, ALUResultOut); end
        end
        run = 1;
        tick();
        run = 0;
        repeat (3) tick();
        compared++; if ({instr_addr, ALUResultOut} !== {6'd2, 32'd10}) begin mismatched++; $display("FAIL run_inflight: got %0d/%h expected 2/0000000a", instr_addr, ALUResultOut); end
        repeat (2) tick();
        compared++; if (instr_addr !== 6'd2) begin mismatched++; $display("FAIL run_hold: got %0d expected 2", instr_addr); end
        run = 1;
        repeat (2) tick();
        reset = 1;
        tick();
        reset = 0;
        compared++; if ({instr_addr, ALUResultOut} !== {6'd0, 32'd0}) begin mismatched++; $display("FAIL abort: got %0d/%h expected 0/00000000", instr_addr, ALUResultOut); end
        repeat (4) tick();
        compared++; if ({instr_addr, ALUResultOut} !== {6'd1, 32'd5}) begin mismatched++; $display("FAIL abort_restart: got %0d/%h expected 1/00000005", instr_addr, ALUResultOut); end
    endtask

    task automatic test_wrap();
        logic [31:0] tgt = RESET_PC + 32'd252;
        clear_rom();
        rom[0] = {6'h02, tgt[27:2]};
        rom[63] = it(6'h08, 0, 8, 16'd7);
        do_reset();
        repeat (2) tick();
        compared++; if ({instr_addr, ALUResultOut} !== {6'd63, 32'd0}) begin mismatched++; $display("FAIL wrap_j: got %0d/%h expected 63/00000000", instr_addr, ALUResultOut); end
        repeat (4) tick();
        compared++; if ({instr_addr, ALUResultOut} !== {6'd0, 32'd7}) begin mismatched++; $display("FAIL wrap_fall: got %0d/%h expected 0/00000007", instr_addr, ALUResultOut); end
`ifdef RETIRE_COUNT_EN
        compared++; if (retire_count !== 32'd2) begin mismatched++; $display("FAIL retire: got %0d expected 2", retire_count); end
`endif
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_arith();
        test_io();
        test_branch();
        test_halt();
        test_run_and_abort();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
